// File: rtl/divider_pkg.sv
// Shared types and constants for the RV32M iterative divider.
package divider_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_CALC,
        DIV_FIXUP,
        DIV_DONE
    } div_state_t;

    // Wide enough for any supported WIDTH; users slice the low WIDTH bits.
    localparam logic [63:0] DIV_ZERO_QUOTIENT = '1;

endpackage

// File: rtl/divider.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle,
// start/ready/done handshake shared with the multiplier.
module divider
    import divider_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    input  logic             start,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int unsigned CW = $clog2(WIDTH);

    div_state_t       state, state_next;
    logic [WIDTH-1:0] dvd, dvs, rem;
    logic [WIDTH-1:0] rem_shift, rem_next;
    logic [WIDTH-1:0] dividend_abs, divisor_abs;
    logic             q_bit;
    logic [CW-1:0]    count;
    logic             neg_quot, neg_rem;
    logic             dividend_neg, divisor_neg;

    always_ff @(posedge clk) begin
        if (rst) state <= DIV_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            DIV_IDLE:  if (start) state_next = (divisor == '0) ? DIV_DONE : DIV_CALC;
            DIV_CALC:  if (count == '0) state_next = DIV_FIXUP;
            DIV_FIXUP: state_next = DIV_DONE;
            DIV_DONE:  state_next = DIV_IDLE;
            default:   state_next = DIV_IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        done  = 1'b0;
        case (state)
            DIV_IDLE: ready = 1'b1;
            DIV_DONE: done  = 1'b1;
            default:  ;
        endcase
    end

    always_comb begin
        dividend_neg = is_signed & dividend[WIDTH-1];
        divisor_neg  = is_signed & divisor[WIDTH-1];
        dividend_abs = dividend_neg ? -dividend : dividend;
        divisor_abs  = divisor_neg  ? -divisor  : divisor;
    end

    // Partial remainder is always below 2**(WIDTH-1) before the last shift,
    // so dropping rem's MSB on the shift loses nothing.
    always_comb begin
        rem_shift = {rem[WIDTH-2:0], dvd[WIDTH-1]};
        if (rem_shift >= dvs) begin
            rem_next = rem_shift - dvs;
            q_bit    = 1'b1;
        end else begin
            rem_next = rem_shift;
            q_bit    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dvd       <= '0;
            dvs       <= '0;
            rem       <= '0;
            count     <= '0;
            neg_quot  <= 1'b0;
            neg_rem   <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        neg_rem  <= dividend_neg;
                        neg_quot <= dividend_neg ^ divisor_neg;
                        dvd      <= dividend_abs;
                        dvs      <= divisor_abs;
                        rem      <= '0;
                        count    <= CW'(WIDTH - 1);
                        if (divisor == '0) begin
                            quotient  <= DIV_ZERO_QUOTIENT[WIDTH-1:0];
                            remainder <= dividend;
                        end
                    end
                end
                DIV_CALC: begin
                    rem <= rem_next;
                    dvd <= {dvd[WIDTH-2:0], q_bit};
                    if (count != '0) count <= count - CW'(1);
                end
                DIV_FIXUP: begin
                    quotient  <= neg_quot ? -dvd : dvd;
                    remainder <= neg_rem  ? -rem : rem;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: table vectors, reset abort, held start and a
// random sweep, all checked through an expected-result queue.
module tb_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dividend, divisor;
    logic        is_signed, start;
    logic        ready, done;
    logic [31:0] quotient, remainder;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[9];

    divider #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .dividend  (dividend),
        .divisor   (divisor),
        .is_signed (is_signed),
        .start     (start),
        .ready     (ready),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r);
        int sa, sb_v;
        if (b == 32'd0) begin
            q = '1;
            r = a;
        end else if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 32'd0;
            end else begin
                sa   = a;
                sb_v = b;
                q    = 32'(sa / sb_v);
                r    = 32'(sa % sb_v);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Called at a negedge; leaves start low and scrambles operands after accept.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input bit push, input logic [31:0] eq, input logic [31:0] er);
        int n = 0;
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check("ready_wait", 32'd0, 32'd1);
        dividend  = a;
        divisor   = b;
        is_signed = s;
        start     = 1'b1;
        @(posedge clk);
        if (push) sb.push_back('{eq, er});
        #1;
        start     = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        is_signed = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(input int exp_lat);
        int   n = 0;
        bit   ready_ok = 1'b1;
        exp_t e;
        do begin
            @(negedge clk);
            n++;
            if (!done && ready) ready_ok = 1'b0;
        end while (!done && n < 100);
        check("done_seen", 32'(done), 32'd1);
        if (done) begin
            if (exp_lat > 0) check("latency", 32'(n), 32'(exp_lat));
            check("ready_low_busy", 32'(ready_ok), 32'd1);
            check("ready_in_done", 32'(ready), 32'd0);
            if (sb.size() == 0) begin
                check("sb_nonempty", 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                check("quotient", quotient, e.q);
                check("remainder", remainder, e.r);
            end
            @(negedge clk);
            check("done_pulse", 32'(done), 32'd0);
            check("ready_after", 32'(ready), 32'd1);
            if (sb.size() == 0) begin
                check("quotient_held", quotient, e.q);
                check("remainder_held", remainder, e.r);
            end
        end
    endtask

    initial begin
        logic [31:0] a, b, eq, er;
        logic        s;
        int          pulses;

        vecs[0] = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          34};
        vecs[1] = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  34};
        vecs[2] = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          34};
        vecs[3] = '{32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5,          1};
        vecs[4] = '{32'hFFFF_FFFB,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFB,  1};
        vecs[5] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          34};
        vecs[6] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  34};
        vecs[7] = '{32'hFFFF_FFFF,  32'hFFFF_FFFE,  1'b0, 32'd1,          32'd1,          34};
        vecs[8] = '{32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b1, 32'd14,         32'hFFFF_FFFE,  34};

        rst = 1'b1; start = 1'b0; dividend = 32'h1234_5678; divisor = 32'd3; is_signed = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quotient", quotient, 32'd0);
        check("rst_remainder", remainder, 32'd0);

        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].s, 1'b1, vecs[i].q, vecs[i].r);
            wait_done(vecs[i].lat);
        end

        // Reset mid-CALC: aborts silently and clears outputs.
        issue(32'hFFFF_FFF0, 32'd3, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_done", 32'(done), 32'd0);
        check("abort_quotient", quotient, 32'd0);
        check("abort_remainder", remainder, 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("abort_no_done", 32'(pulses), 32'd0);
        issue(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd0);
        wait_done(34);

        // start held high: one done pulse, mid-CALC operand change ignored, re-accept.
        dividend = 32'd1000; divisor = 32'd9; is_signed = 1'b0; start = 1'b1;
        @(posedge clk);
        sb.push_back('{32'd111, 32'd1});
        #1;
        repeat (5) @(negedge clk);
        dividend = 32'hFFFF_FC18; divisor = 32'd9; is_signed = 1'b1;
        wait_done(29);
        @(posedge clk);
        sb.push_back('{32'hFFFF_FF91, 32'hFFFF_FFFF});
        #1 start = 1'b0;
        wait_done(34);

        for (int i = 0; i < 12; i++) begin
            a = $urandom;
            case (i % 4)
                0: b = $urandom;
                1: b = 32'($urandom_range(1, 20));
                2: b = (i == 6) ? 32'd0 : 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            s = 1'($urandom_range(0, 1));
            model(a, b, s, eq, er);
            issue(a, b, s, 1'b1, eq, er);
            wait_done(b == 32'd0 ? 1 : 34);
        end

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
